// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, NOP encoding, fetch FSM states and
// the IF/ID register layout.
package pipeline_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Sequential PC; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and
// instruction memory (slave). imem_addr is held while a request waits.
interface fetch_stage_if;
  import pipeline_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid register: catches a word that returns while decode is
// stalled so the fetch pipe can stop without losing it.
// Priority: clear > load > drain.
module fetch_hold_buf
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] wr_instr,
  input  logic [XLEN-1:0] wr_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Entry state: capture on load, empty on drain or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= wr_instr;
      pc    <= wr_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline stage 1: instruction fetch. Owns the PC, talks to instruction
// memory over req/ack, absorbs stalls via a one-entry hold buffer and
// handles redirects, including ones that race an outstanding request.
// Optional: define FETCH_PERF_CNT_EN to add fetch/bubble counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count_out,
  output logic [XLEN-1:0] bubble_count_out
`endif
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] redirect_pc, redirect_pc_nxt;
  ifid_t           ifid;

  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic req;
  logic accept;
  logic hb_load;
  logic hb_drain;
  logic load_bubble;

  // A full hold buffer throttles fetch until decode takes the word.
  assign req      = (state != IDLE) && !hold_valid;
  assign accept   = imem.imem_ack && req && (state == REQ) && !branch_taken;
  assign hb_load  = accept && stall;
  assign hb_drain = hold_valid && !stall && !branch_taken;

  // Bubble on redirect, or when decode is free and there is nothing to give it.
  assign load_bubble = branch_taken || (!stall && !accept && !hold_valid);

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc;

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hb_load),
    .drain    (hb_drain),
    .clear    (branch_taken),
    .wr_instr (imem.imem_rdata),
    .wr_pc    (fetch_pc),
    .valid    (hold_valid),
    .instr    (hold_instr),
    .pc       (hold_pc)
  );

  // FSM, fetch PC and redirect PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      redirect_pc <= RESET_PC;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

  // Next state / next PC. A redirect that races a pending request must wait
  // for the stale ack (memory cannot cancel), so the target parks in
  // redirect_pc and imem_addr stays on the stale address meanwhile.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    redirect_pc_nxt = redirect_pc;
    if (branch_taken) begin
      if (req && !imem.imem_ack) begin
        state_nxt       = KILL;
        redirect_pc_nxt = branch_target;
      end else begin
        fetch_pc_nxt = branch_target;
        state_nxt    = REQ;
      end
    end else if (state == KILL && imem.imem_ack) begin
      fetch_pc_nxt = redirect_pc;
      state_nxt    = REQ;
    end else if (accept) begin
      fetch_pc_nxt = next_pc(fetch_pc);
    end
    if (state == IDLE) state_nxt = REQ;
  end

  // IF/ID register: flush > drain hold buffer > fresh word > bubble; stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid <= '0;
    end else if (load_bubble) begin
      ifid.valid <= 1'b0;
      ifid.instr <= NOP_INSTR;
    end else if (hb_drain) begin
      ifid.valid    <= 1'b1;
      ifid.instr    <= hold_instr;
      ifid.pc       <= hold_pc;
      ifid.pc_plus4 <= next_pc(hold_pc);
    end else if (accept && !stall) begin
      ifid.valid    <= 1'b1;
      ifid.instr    <= imem.imem_rdata;
      ifid.pc       <= fetch_pc;
      ifid.pc_plus4 <= next_pc(fetch_pc);
    end
  end

  assign instr_out    = ifid.instr;
  assign pc_out       = ifid.pc;
  assign pc_plus4_out = ifid.pc_plus4;
  assign valid_out    = ifid.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt;
  logic [XLEN-1:0] bubble_cnt;

  // Free-running event counters; wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (accept)      fetch_cnt  <= fetch_cnt + 1'b1;
      if (load_bubble) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign fetch_count_out  = fetch_cnt;
  assign bubble_count_out = bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table (inputs plus expected bus
// and IF/ID values) followed by hand sequences for redirect-in-KILL and
// mid-operation reset.
module tb_fetch_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
  logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_out, bubble_count_out;
`endif

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .pc_plus4_out  (pc_plus4_out),
    .valid_out     (valid_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_out  (fetch_count_out),
    .bubble_count_out (bubble_count_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        req;    // expected during the cycle
    logic [31:0] addr;
    logic        valid;  // expected after the edge
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        acc;    // this cycle is an accepted fetch
  } vec_t;

  int total = 0;
  int bad   = 0;
  int exp_fetch  = 0;
  int exp_bubble = 0;
  vec_t tbl[26];

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic a, logic [31:0] d,
                              logic rq, logic [31:0] ad, logic v, logic [31:0] i,
                              logic [31:0] p, logic [31:0] p4, logic ac);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.ack = a; r.rdata = d;
    r.req = rq; r.addr = ad; r.valid = v; r.instr = i; r.pc = p; r.pc4 = p4; r.acc = ac;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    stall = v.stall;
    branch_taken = v.br;
    branch_target = v.tgt;
    imem_bus.imem_ack = v.ack;
    imem_bus.imem_rdata = v.rdata;
    #1;
    chk({tag, " req"},  {31'b0, imem_bus.imem_req}, {31'b0, v.req});
    chk({tag, " addr"}, imem_bus.imem_addr, v.addr);
    @(posedge clk);
    #1;
    chk({tag, " valid"}, {31'b0, valid_out}, {31'b0, v.valid});
    chk({tag, " instr"}, instr_out, v.instr);
    chk({tag, " pc"},    pc_out, v.pc);
    chk({tag, " pc4"},   pc_plus4_out, v.pc4);
    if (v.acc) exp_fetch++;
    if (!v.valid && (!v.stall || v.br)) exp_bubble++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"},   {31'b0, imem_bus.imem_req}, 32'h0);
    chk({tag, " addr"},  imem_bus.imem_addr, 32'h0);
    chk({tag, " valid"}, {31'b0, valid_out}, 32'h0);
    chk({tag, " instr"}, instr_out, 32'h0);
    chk({tag, " pc"},    pc_out, 32'h0);
    chk({tag, " pc4"},   pc_plus4_out, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            st br tgt           ack rdata         req addr          v  instr         pc            pc4           acc
    // streaming from reset
    tbl[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);
    tbl[1]  = mk(0, 0, 32'h0,        1, 32'hA5A50000, 1, 32'h0,        1, 32'hA5A50000, 32'h0,        32'h4,        1);
    tbl[2]  = mk(0, 0, 32'h0,        1, 32'hA5A50004, 1, 32'h4,        1, 32'hA5A50004, 32'h4,        32'h8,        1);
    tbl[3]  = mk(0, 0, 32'h0,        1, 32'hA5A50008, 1, 32'h8,        1, 32'hA5A50008, 32'h8,        32'hC,        1);
    // 3-cycle ack latency
    tbl[4]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        0, 32'h0,        32'h8,        32'hC,        0);
    tbl[5]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        0, 32'h0,        32'h8,        32'hC,        0);
    tbl[6]  = mk(0, 0, 32'h0,        1, 32'hA5A5000C, 1, 32'hC,        1, 32'hA5A5000C, 32'hC,        32'h10,       1);
    // stall for 4 cycles: one word parks in the hold buffer
    tbl[7]  = mk(1, 0, 32'h0,        1, 32'hA5A50010, 1, 32'h10,       1, 32'hA5A5000C, 32'hC,        32'h10,       1);
    tbl[8]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h14,       1, 32'hA5A5000C, 32'hC,        32'h10,       0);
    tbl[9]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h14,       1, 32'hA5A5000C, 32'hC,        32'h10,       0);
    tbl[10] = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h14,       1, 32'hA5A5000C, 32'hC,        32'h10,       0);
    tbl[11] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h14,       1, 32'hA5A50010, 32'h10,       32'h14,       0);
    tbl[12] = mk(0, 0, 32'h0,        1, 32'hA5A50014, 1, 32'h14,       1, 32'hA5A50014, 32'h14,       32'h18,       1);
    tbl[13] = mk(0, 0, 32'h0,        1, 32'hA5A50018, 1, 32'h18,       1, 32'hA5A50018, 32'h18,       32'h1C,       1);
    tbl[14] = mk(0, 0, 32'h0,        1, 32'hA5A5001C, 1, 32'h1C,       1, 32'hA5A5001C, 32'h1C,       32'h20,       1);
    // branch to 0x100 while 0x20 is pending: stale ack is dropped
    tbl[15] = mk(0, 1, 32'h100,      0, 32'h0,        1, 32'h20,       0, 32'h0,        32'h1C,       32'h20,       0);
    tbl[16] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h20,       0, 32'h0,        32'h1C,       32'h20,       0);
    tbl[17] = mk(0, 0, 32'h0,        1, 32'hA5A50020, 1, 32'h20,       0, 32'h0,        32'h1C,       32'h20,       0);
    tbl[18] = mk(0, 0, 32'h0,        1, 32'hA5A50100, 1, 32'h100,      1, 32'hA5A50100, 32'h100,      32'h104,      1);
    // branch coincident with ack while stalled
    tbl[19] = mk(1, 1, 32'h200,      1, 32'hA5A50104, 1, 32'h104,      0, 32'h0,        32'h100,      32'h104,      0);
    tbl[20] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h200,      0, 32'h0,        32'h100,      32'h104,      0);
    tbl[21] = mk(0, 0, 32'h0,        1, 32'hA5A50200, 1, 32'h200,      1, 32'hA5A50200, 32'h200,      32'h204,      1);
    // PC wrap at the top of the address space
    tbl[22] = mk(0, 1, 32'hFFFFFFFC, 1, 32'hA5A50204, 1, 32'h204,      0, 32'h0,        32'h200,      32'h204,      0);
    tbl[23] = mk(0, 0, 32'h0,        1, 32'h5A5AFFFC, 1, 32'hFFFFFFFC, 1, 32'h5A5AFFFC, 32'hFFFFFFFC, 32'h0,        1);
    tbl[24] = mk(0, 0, 32'h0,        1, 32'hA5A50000, 1, 32'h0,        1, 32'hA5A50000, 32'h0,        32'h4,        1);
    tbl[25] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0,        32'h4,        0);

    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
`ifdef FETCH_PERF_CNT_EN
    chk("reset fcnt", fetch_count_out, 32'h0);
    chk("reset bcnt", bubble_count_out, 32'h0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

    // second branch during KILL replaces the parked target
    step("k0", mk(0, 1, 32'h300, 0, 32'h0,      1, 32'h4,   0, 32'h0,      32'h0,   32'h4,   0));
    step("k1", mk(0, 1, 32'h400, 0, 32'h0,      1, 32'h4,   0, 32'h0,      32'h0,   32'h4,   0));
    step("k2", mk(0, 0, 32'h0,   1, 32'hDEADBEEF, 1, 32'h4, 0, 32'h0,      32'h0,   32'h4,   0));
    step("k3", mk(0, 0, 32'h0,   1, 32'h12345678, 1, 32'h400, 1, 32'h12345678, 32'h400, 32'h404, 1));

`ifdef FETCH_PERF_CNT_EN
    chk("fetch count",  fetch_count_out, exp_fetch);
    chk("bubble count", bubble_count_out, exp_bubble);
`endif

    // reset mid-operation with a request outstanding
    step("m0", mk(0, 0, 32'h0, 0, 32'h0, 1, 32'h404, 0, 32'h0, 32'h400, 32'h404, 0));
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    step("r0", mk(0, 0, 32'h0, 0, 32'h0,        0, 32'h0, 0, 32'h0,        32'h0, 32'h0, 0));
    step("r1", mk(0, 0, 32'h0, 1, 32'hCAFE0000, 1, 32'h0, 1, 32'hCAFE0000, 32'h0, 32'h4, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Pipeline stage 1: instruction fetch. Owns the program counter and issues word requests to instruction memory over a req/ack handshake. Absorbs variable memory latency, hazard-unit stalls and branch redirects, and drives the IF/ID pipeline register consumed by the Decode stage (`instr_in`).

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit; hold IF/ID contents.
- `branch_taken`  in  1  redirect request from a later stage; single-cycle pulse.
- `branch_target`  in  32  redirect PC, valid while `branch_taken`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req && !imem_ack`.
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `instr_out`  out  32  IF/ID instruction.
- `pc_out`  out  32  IF/ID PC.
- `pc_plus4_out`  out  32  IF/ID PC+4.
- `valid_out`  out  1  IF/ID holds a real instruction; 0 means bubble, with `instr_out` = NOP.

## Operation
- State machine states:
  - IDLE: reset only.
  - REQ: a request is live or can issue.
  - KILL: an outstanding request is stale.
- Transitions:
  - IDLE -> REQ unconditionally on the first clock after reset release.
  - REQ -> KILL on `branch_taken && imem_req && !imem_ack`.
  - KILL -> REQ on `imem_ack`.
- `imem_req` = (state != IDLE) && !hold_valid.
- `imem_addr` = `fetch_pc` register.
- Accept = `imem_ack` in REQ without `branch_taken`. On accept, `fetch_pc <= fetch_pc + 4`, with modulo 2^32 wrap.
- Accepted word routing:
  - `stall` = 0: the word goes to IF/ID.
  - `stall` = 1: the word goes to a one-entry hold buffer (`hold_valid` = 1).
- Hold buffer handling:
  - While `hold_valid`, no request issues.
  - When `stall` falls, IF/ID loads from the hold buffer and `hold_valid` clears.
  - The next request issues in the following cycle.
- `stall` = 0 and no accepted word: IF/ID loads a bubble (`valid_out` = 0, `instr_out` = 32'h0). Other IF/ID fields hold their values.
- `branch_taken` has highest priority and overrides `stall`:
  - IF/ID is flushed to a bubble and the hold buffer is cleared.
  - An ack in the same cycle is discarded.
  - If a request is left outstanding (not acked this cycle), enter KILL and latch `branch_target` into `redirect_pc`. `fetch_pc` and `imem_addr` keep the stale address until ack.
  - Otherwise `fetch_pc <= branch_target`.
- KILL behaviour:
  - On ack, `rdata` is dropped and `fetch_pc <= redirect_pc`.
  - A further `branch_taken` during KILL overwrites `redirect_pc`.
- `pc_plus4_out` = captured PC + 4, computed at the same load as `pc_out`.
- `branch_target` is used unaligned as given; no check is made.

## Timing
- Reset values:
  - `fetch_pc` = `RESET_PC`, state IDLE, `hold_valid` = 0.
  - All outputs 0, including `imem_req`.
- First `imem_req` at `RESET_PC` is in the first cycle after the first post-reset edge.
- Fetch latency: ack in cycle N -> IF/ID valid in N+1.
- Throughput: one instruction per cycle with back-to-back acks. `imem_addr` advances in N+1.
- Redirect, no outstanding request: branch in cycle N -> request at target in N+1.
- Redirect with outstanding request: the target request starts the cycle after the stale ack.
- Stall release with hold buffer: IF/ID updates on the edge where `stall` is first sampled 0.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - The outstanding request is abandoned; instruction memory shares `rst_n`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two 32-bit output ports.
  - `fetch_count_out` increments on each accept.
  - `bubble_count_out` increments on each edge that loads a bubble into IF/ID.
  - Both reset to 0 and wrap at 2^32.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `pipeline_pkg`:
  - `XLEN` = 32.
  - `NOP_INSTR` = 32'h0.
  - Fetch state enum (IDLE, REQ, KILL).
  - `PC_STEP` = 4.
- One natural sub-module: `fetch_hold_buf`, a one-entry skid register holding instr/pc with load, drain and clear.
- FSM, PC logic and IF/ID register stay in `fetch_stage`.

## Test plan
- Reset release, memory acks every cycle with rdata = addr ^ 32'hA5A5_0000 -> addresses 0, 4, 8, …; IF/ID matches one cycle after each ack; `valid_out` continuous.
- Ack delayed 3 cycles per request -> `imem_addr` stable during the wait; IF/ID shows bubbles between instructions; `pc_out` increments by 4 per instruction.
- `stall` high 4 cycles during streaming -> IF/ID frozen; exactly one word captured into the hold buffer; `imem_req` low while the buffer is full; no instruction lost or duplicated after release.
- `branch_taken` to 32'h100 while a request at 32'h20 is pending -> KILL; stale ack data never appears on `valid_out`; next request at 32'h100.
- `branch_taken` in the same cycle as ack, with `stall` high -> IF/ID bubble, hold buffer empty, next request at target.
- `fetch_pc` at 32'hFFFF_FFFC with ack -> next address 32'h0; with `FETCH_PERF_CNT_EN` defined, counters match the scoreboard.
